// File: rtl/button_dir_ctrl.sv
// Button front end: 2-flop sync, per-button debounce, press pulses and move-gated heading.
// Optional macro DIR_QUEUE_EN swaps the single pending heading for a 2-entry heading FIFO.

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_i,
    output logic level_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             level_q;

    // Any sample equal to the accepted level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sync_i == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            level_q <= ~level_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign level_o = level_q;
endmodule

module button_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] button_in,
    input  logic       move_tick,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic       middle_pulse,
    output logic [1:0] dir,
    output logic       dir_changed
);
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    logic [4:0] sync1_q, sync2_q, level_w, level_dly_q, press_q;
    logic [1:0] dir_q, dir_d;
    logic       chg_q, chg_d, dchg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_dly_q <= '0;
            press_q     <= '0;
        end else begin
            sync1_q     <= button_in;
            sync2_q     <= sync1_q;
            level_dly_q <= level_w;
            press_q     <= level_w & ~level_dly_q;
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db [4:0] (
        .clk    (clk),
        .rst_n  (rst_n),
        .sync_i (sync2_q),
        .level_o(level_w)
    );

    function automatic logic [1:0] opp(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    logic       req_vld;
    logic [1:0] req;

    always_comb begin
        req_vld = |press_q[4:1];
        req     = DIR_RIGHT;
        if (press_q[1])      req = DIR_UP;
        else if (press_q[2]) req = DIR_DOWN;
        else if (press_q[3]) req = DIR_LEFT;
    end

`ifdef DIR_QUEUE_EN
    logic [1:0] q0_q, q1_q, q0_d, q1_d, e0, tail;
    logic [1:0] fcnt_q, fcnt_d, ecnt;
    logic       pop, accept;

    // Pop happens first, so a push lands behind whatever remains after the pop.
    always_comb begin
        pop    = move_tick && (fcnt_q != 2'd0);
        ecnt   = pop ? fcnt_q - 2'd1 : fcnt_q;
        e0     = pop ? q1_q : q0_q;
        dir_d  = pop ? q0_q : dir_q;
        tail   = (ecnt == 2'd2) ? q1_q : (ecnt == 2'd1) ? e0 : dir_d;
        accept = req_vld && (ecnt != 2'd2) && (req != tail) && (req != opp(tail));
        q0_d   = e0;
        q1_d   = q1_q;
        fcnt_d = ecnt;
        if (accept) begin
            if (ecnt == 2'd0) q0_d = req;
            else              q1_d = req;
            fcnt_d = ecnt + 2'd1;
        end
        chg_d  = pop && (q0_q != dir_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0_q   <= DIR_RIGHT;
            q1_q   <= DIR_RIGHT;
            fcnt_q <= '0;
        end else begin
            q0_q   <= q0_d;
            q1_q   <= q1_d;
            fcnt_q <= fcnt_d;
        end
    end
`else
    logic [1:0] pend_q, pend_d, ref_dir;
    logic       pv_q, pv_d, commit, eff_pv, accept;

    // A same-cycle request is judged against the heading being committed now.
    always_comb begin
        commit  = move_tick && pv_q;
        dir_d   = commit ? pend_q : dir_q;
        eff_pv  = pv_q && !move_tick;
        ref_dir = eff_pv ? pend_q : dir_d;
        accept  = req_vld && (req != ref_dir) && (req != opp(ref_dir)) && (req != opp(dir_d));
        pend_d  = accept ? req : pend_q;
        pv_d    = accept || eff_pv;
        chg_d   = commit && (pend_q != dir_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= DIR_RIGHT;
            pv_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            pv_q   <= pv_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q  <= DIR_RIGHT;
            chg_q  <= 1'b0;
            dchg_q <= 1'b0;
        end else begin
            dir_q  <= dir_d;
            chg_q  <= chg_d;
            dchg_q <= chg_q;
        end
    end

    assign btn_level    = level_w;
    assign btn_press    = press_q;
    assign middle_pulse = press_q[0];
    assign dir          = dir_q;
    assign dir_changed  = dchg_q;
endmodule

// File: tb/tb_button_dir_ctrl.sv
// Scoreboard bench for button_dir_ctrl with a short debounce window.
module tb_button_dir_ctrl;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] button_in = '0;
    logic       move_tick = 1'b0;
    logic [4:0] btn_level, btn_press;
    logic       middle_pulse, dir_changed;
    logic [1:0] dir;

    button_dir_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button_in   (button_in),
        .move_tick   (move_tick),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .middle_pulse(middle_pulse),
        .dir         (dir),
        .dir_changed (dir_changed)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [4:0] exp_press_q[$];
    logic [1:0] exp_dir_q[$];
    logic [4:0] mon_press;
    logic [1:0] mon_dir;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        exp_press_q.push_back(b);
        button_in = b;
        cyc(10);
        button_in = '0;
        cyc(10);
    endtask

    task automatic tick(input logic [1:0] exp, input bit chg);
        if (chg) exp_dir_q.push_back(exp);
        move_tick = 1'b1;
        @(posedge clk);
        #1;
        move_tick = 1'b0;
        @(negedge clk);
        chk("dir_commit", 32'(dir), 32'(exp));
        chk("dchg_early", 32'(dir_changed), 0);
        cyc(4);
    endtask

    // Check debounced level of bit b is low 5 edges after the drive and high on the 6th.
    task automatic lvl_edge(input int b);
        repeat (DB + 1) @(posedge clk);
        @(negedge clk);
        chk("lvl_early", 32'(btn_level[b]), 0);
        @(posedge clk);
        @(negedge clk);
        chk("lvl_rise", 32'(btn_level[b]), 1);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (btn_press != '0) begin
                if (exp_press_q.size() == 0) begin
                    chk("press_spurious", 32'(btn_press), 0);
                end else begin
                    mon_press = exp_press_q.pop_front();
                    chk("press", 32'(btn_press), 32'(mon_press));
                    chk("middle", 32'(middle_pulse), 32'(mon_press[0]));
                end
            end
            if (dir_changed) begin
                if (exp_dir_q.size() == 0) begin
                    chk("dchg_spurious", 32'(dir_changed), 0);
                end else begin
                    mon_dir = exp_dir_q.pop_front();
                    chk("dchg_dir", 32'(dir), 32'(mon_dir));
                end
            end
        end
    end

    initial begin
        cyc(2);
        chk("rst_dir", 32'(dir), 3);
        chk("rst_level", 32'(btn_level), 0);
        chk("rst_press", 32'(btn_press), 0);
        chk("rst_dchg", 32'(dir_changed), 0);
        chk("rst_middle", 32'(middle_pulse), 0);
        rst_n = 1'b1;
        cyc(2);

        // Left against right heading is a reversal
        press(5'b01000);
        tick(2'b11, 1'b0);

        // Up press, level timing, commit only on tick
        exp_press_q.push_back(5'b00010);
        button_in = 5'b00010;
        lvl_edge(1);
        cyc(4);
        button_in = '0;
        cyc(10);
        chk("dir_hold", 32'(dir), 3);
        tick(2'b00, 1'b1);

        // Bounce never reaches the stability count
        for (int k = 0; k < 4; k++) begin
            button_in[3] = (k % 2 == 0);
            cyc(1);
        end
        button_in = '0;
        for (int k = 0; k < 8; k++) begin
            chk("bounce_lvl", 32'(btn_level[3]), 0);
            cyc(1);
        end

        // Back to right, then up followed by down (down reverses the pending up)
        press(5'b10000);
        tick(2'b11, 1'b1);
        press(5'b00010);
        press(5'b00100);
`ifdef DIR_QUEUE_EN
        press(5'b01000);
        tick(2'b00, 1'b1);
        tick(2'b10, 1'b1);
`else
        tick(2'b00, 1'b1);
        press(5'b01000);
        tick(2'b10, 1'b1);
`endif
        tick(2'b10, 1'b0);

        // Up and right together: up has priority
        press(5'b10010);
        tick(2'b00, 1'b1);

        // Reset in the middle of a debounce count
        button_in = 5'b00100;
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("arst_dir", 32'(dir), 3);
        chk("arst_level", 32'(btn_level), 0);
        chk("arst_press", 32'(btn_press), 0);
        cyc(2);
        rst_n = 1'b1;
        exp_press_q.push_back(5'b00100);
        lvl_edge(2);
        cyc(4);
        button_in = '0;
        cyc(10);
        tick(2'b01, 1'b1);

        chk("press_q_empty", 32'(exp_press_q.size()), 0);
        chk("dir_q_empty", 32'(exp_dir_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
